// File: rtl/pulse_param_pkg.sv
// Shared types, address map and reset defaults for the pulse parameter loader.
package pulse_param_pkg;

    localparam logic [7:0] HEADER_DEFAULT       = 8'hA5;

    localparam logic [7:0] ADDR_PERIOD          = 8'd0;
    localparam logic [7:0] ADDR_P1WIDTH         = 8'd1;
    localparam logic [7:0] ADDR_DELAY           = 8'd2;
    localparam logic [7:0] ADDR_P2WIDTH         = 8'd3;
    localparam logic [7:0] ADDR_ATT             = 8'd4;
    localparam logic [7:0] ADDR_CPMG            = 8'd5;
    localparam logic [7:0] ADDR_PULSE_BLOCK     = 8'd6;
    localparam logic [7:0] ADDR_PULSE_BLOCK_OFF = 8'd7;
    localparam logic [7:0] ADDR_FLAGS           = 8'd8;
    localparam logic [7:0] ADDR_COMMIT          = 8'd9;

    localparam logic [31:0] DEF_PERIOD_DEFAULT  = 32'd200000;
    localparam logic [31:0] DEF_P1WIDTH         = 32'd20;
    localparam logic [31:0] DEF_DELAY           = 32'd200;
    localparam logic [31:0] DEF_P2WIDTH         = 32'd40;
    localparam logic [6:0]  DEF_PRE_ATT         = 7'd0;
    localparam logic [6:0]  DEF_POST_ATT        = 7'd0;
    localparam logic [7:0]  DEF_CPMG            = 8'd1;
    localparam logic [7:0]  DEF_PULSE_BLOCK     = 8'd50;
    localparam logic [15:0] DEF_PULSE_BLOCK_OFF = 16'd100;
    localparam logic        DEF_PUMP            = 1'b1;
    localparam logic        DEF_BLOCK           = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] p1width;
        logic [31:0] delay;
        logic [31:0] p2width;
        logic [6:0]  pre_att;
        logic [6:0]  post_att;
        logic [7:0]  cpmg;
        logic [7:0]  pulse_block;
        logic [15:0] pulse_block_off;
        logic        pump;
        logic        block;
    } pulse_params_t;

    function automatic pulse_params_t default_params(input logic [31:0] def_period);
        pulse_params_t p;
        p.period          = def_period;
        p.p1width         = DEF_P1WIDTH;
        p.delay           = DEF_DELAY;
        p.p2width         = DEF_P2WIDTH;
        p.pre_att         = DEF_PRE_ATT;
        p.post_att        = DEF_POST_ATT;
        p.cpmg            = DEF_CPMG;
        p.pulse_block     = DEF_PULSE_BLOCK;
        p.pulse_block_off = DEF_PULSE_BLOCK_OFF;
        p.pump            = DEF_PUMP;
        p.block           = DEF_BLOCK;
        return p;
    endfunction

    function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [31:0] data);
        return addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

    // Narrow fields take the low bits of the word; unknown addresses leave the set untouched.
    function automatic pulse_params_t write_field(input pulse_params_t cur,
                                                  input logic [7:0]    addr,
                                                  input logic [31:0]   data);
        pulse_params_t p;
        p = cur;
        case (addr)
            ADDR_PERIOD:          p.period          = data;
            ADDR_P1WIDTH:         p.p1width         = data;
            ADDR_DELAY:           p.delay           = data;
            ADDR_P2WIDTH:         p.p2width         = data;
            ADDR_ATT: begin
                p.pre_att  = data[14:8];
                p.post_att = data[6:0];
            end
            ADDR_CPMG:            p.cpmg            = data[7:0];
            ADDR_PULSE_BLOCK:     p.pulse_block     = data[7:0];
            ADDR_PULSE_BLOCK_OFF: p.pulse_block_off = data[15:0];
            ADDR_FLAGS: begin
                p.pump  = data[0];
                p.block = data[1];
            end
            default:              p = cur;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pulse_param_loader_if.sv
// Byte stream from the host UART receiver into the parameter loader.
interface pulse_param_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/pulse_param_loader_frame_rx.sv
// Frame parser: HEADER, ADDR, D3..D0, CSUM -> one-cycle {addr, data, wr} strobe or frame_err.
// Optional inter-byte timeout when FRAME_TIMEOUT_EN is defined.
module param_frame_rx
    import pulse_param_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                 clk_pll,
    input  logic                 reset,
    pulse_param_loader_if.slave  rx,
    output logic [7:0]           wr_addr,
    output logic [31:0]          wr_data,
    output logic                 wr,
    output logic                 frame_err
);

    frame_state_t state_r, state_nxt;
    logic [7:0]   addr_r, addr_nxt;
    logic [31:0]  data_r, data_nxt;
    logic [1:0]   idx_r, idx_nxt;
    logic         wr_r, wr_nxt;
    logic         err_r, err_nxt;

`ifdef FRAME_TIMEOUT_EN
    logic [31:0]  gap_r, gap_nxt;
`else
    logic         unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYC == 0);
`endif

    // Next-state, byte assembly and checksum verdict.
    always_comb begin
        state_nxt = state_r;
        addr_nxt  = addr_r;
        data_nxt  = data_r;
        idx_nxt   = idx_r;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (rx.rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx.rx_data == HEADER) begin
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    addr_nxt  = rx.rx_data;
                    idx_nxt   = 2'd0;
                    state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    data_nxt = {data_r[23:0], rx.rx_data};
                    idx_nxt  = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    state_nxt = ST_IDLE;
                    if ((rx.rx_data == frame_csum(addr_r, data_r)) && (addr_r <= ADDR_COMMIT)) begin
                        wr_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else begin
            state_nxt = state_r;
        end

`ifdef FRAME_TIMEOUT_EN
        gap_nxt = 32'd0;
        if ((state_r != ST_IDLE) && !rx.rx_valid) begin
            if (gap_r >= (TIMEOUT_CYC - 32'd1)) begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b1;
                gap_nxt   = 32'd0;
            end else begin
                gap_nxt = gap_r + 32'd1;
            end
        end else begin
            gap_nxt = 32'd0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Frame datapath and registered strobes.
    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            addr_r <= 8'd0;
            data_r <= 32'd0;
            idx_r  <= 2'd0;
            wr_r   <= 1'b0;
            err_r  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            gap_r  <= 32'd0;
`endif
        end else begin
            addr_r <= addr_nxt;
            data_r <= data_nxt;
            idx_r  <= idx_nxt;
            wr_r   <= wr_nxt;
            err_r  <= err_nxt;
`ifdef FRAME_TIMEOUT_EN
            gap_r  <= gap_nxt;
`endif
        end
    end

    // addr_r/data_r are stable for the strobe cycle: the next ADDR byte needs a HEADER first.
    assign wr_addr   = addr_r;
    assign wr_data   = data_r;
    assign wr        = wr_r;
    assign frame_err = err_r;

endmodule

// File: rtl/pulse_param_loader.sv
// Shadow/active parameter banks for the pulse sequencer; shadow copied to active on a
// period boundary after COMMIT. FRAME_TIMEOUT_EN enables the inter-byte frame timeout.
module pulse_param_loader
    import pulse_param_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter logic [31:0] DEF_PERIOD  = DEF_PERIOD_DEFAULT
) (
    input  logic                 clk_pll,
    input  logic                 reset,
    pulse_param_loader_if.slave  rx,
    input  logic                 cycle_start,
    output logic [31:0]          period,
    output logic [31:0]          p1width,
    output logic [31:0]          delay,
    output logic [31:0]          p2width,
    output logic [6:0]           pre_att,
    output logic [6:0]           post_att,
    output logic [7:0]           cpmg,
    output logic [7:0]           pulse_block,
    output logic [15:0]          pulse_block_off,
    output logic                 pump,
    output logic                 block,
    output logic                 commit_pending,
    output logic                 frame_err,
    output logic                 applied
);

    localparam pulse_params_t RESET_PARAMS = default_params(DEF_PERIOD);

    logic [7:0]    wr_addr_s;
    logic [31:0]   wr_data_s;
    logic          wr_s;
    logic          commit_wr_s;
    logic          apply_s;

    pulse_params_t shadow_r, shadow_nxt;
    pulse_params_t active_r, active_nxt;
    logic          commit_pending_r, commit_pending_nxt;
    logic          applied_r, applied_nxt;

    param_frame_rx #(
        .HEADER      (HEADER),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk_pll   (clk_pll),
        .reset     (reset),
        .rx        (rx),
        .wr_addr   (wr_addr_s),
        .wr_data   (wr_data_s),
        .wr        (wr_s),
        .frame_err (frame_err)
    );

    assign commit_wr_s = wr_s && (wr_addr_s == ADDR_COMMIT);
    assign apply_s     = cycle_start && commit_pending_r;

    // Shadow write, boundary apply and commit bookkeeping.
    always_comb begin
        shadow_nxt         = shadow_r;
        active_nxt         = active_r;
        applied_nxt        = 1'b0;
        commit_pending_nxt = commit_pending_r;
        if (wr_s && !commit_wr_s) begin
            shadow_nxt = write_field(shadow_r, wr_addr_s, wr_data_s);
        end else begin
            shadow_nxt = shadow_r;
        end
        if (apply_s) begin
            active_nxt  = shadow_r;
            applied_nxt = 1'b1;
        end else begin
            active_nxt  = active_r;
            applied_nxt = 1'b0;
        end
        // A COMMIT landing on the apply cycle stays pending for the next boundary.
        commit_pending_nxt = (commit_pending_r && !apply_s) || commit_wr_s;
    end

    // Parameter banks and status registers.
    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            shadow_r         <= RESET_PARAMS;
            active_r         <= RESET_PARAMS;
            commit_pending_r <= 1'b0;
            applied_r        <= 1'b0;
        end else begin
            shadow_r         <= shadow_nxt;
            active_r         <= active_nxt;
            commit_pending_r <= commit_pending_nxt;
            applied_r        <= applied_nxt;
        end
    end

    assign period          = active_r.period;
    assign p1width         = active_r.p1width;
    assign delay           = active_r.delay;
    assign p2width         = active_r.p2width;
    assign pre_att         = active_r.pre_att;
    assign post_att        = active_r.post_att;
    assign cpmg            = active_r.cpmg;
    assign pulse_block     = active_r.pulse_block;
    assign pulse_block_off = active_r.pulse_block_off;
    assign pump            = active_r.pump;
    assign block           = active_r.block;
    assign commit_pending  = commit_pending_r;
    assign applied         = applied_r;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Self-checking bench for pulse_param_loader: directed steps plus randomized frames
// checked against a word-per-address reference model.
module tb_pulse_param_loader;

    logic        clk_pll = 1'b0;
    logic        reset;
    logic        cycle_start;
    logic [31:0] period, p1width, delay, p2width;
    logic [6:0]  pre_att, post_att;
    logic [7:0]  cpmg, pulse_block;
    logic [15:0] pulse_block_off;
    logic        pump, block, commit_pending, frame_err, applied;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_shadow [0:8];
    logic [31:0] m_act    [0:8];
    logic        m_pending;

    pulse_param_loader_if bus ();

    pulse_param_loader #(.TIMEOUT_CYC(16)) dut (
        .clk_pll         (clk_pll),
        .reset           (reset),
        .rx              (bus),
        .cycle_start     (cycle_start),
        .period          (period),
        .p1width         (p1width),
        .delay           (delay),
        .p2width         (p2width),
        .pre_att         (pre_att),
        .post_att        (post_att),
        .cpmg            (cpmg),
        .pulse_block     (pulse_block),
        .pulse_block_off (pulse_block_off),
        .pump            (pump),
        .block           (block),
        .commit_pending  (commit_pending),
        .frame_err       (frame_err),
        .applied         (applied)
    );

    always #5 clk_pll = ~clk_pll;

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow[0] = 32'd200000;
        m_shadow[1] = 32'd20;
        m_shadow[2] = 32'd200;
        m_shadow[3] = 32'd40;
        m_shadow[4] = 32'd0;
        m_shadow[5] = 32'd1;
        m_shadow[6] = 32'd50;
        m_shadow[7] = 32'd100;
        m_shadow[8] = 32'd1;
        for (int i = 0; i < 9; i++) m_act[i] = m_shadow[i];
        m_pending = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] w4, w8;
        w4 = m_act[4];
        w8 = m_act[8];
        chk({tag, ".period"},  period,  m_act[0]);
        chk({tag, ".p1width"}, p1width, m_act[1]);
        chk({tag, ".delay"},   delay,   m_act[2]);
        chk({tag, ".p2width"}, p2width, m_act[3]);
        chk({tag, ".pre_att"}, {25'd0, pre_att},  {25'd0, w4[14:8]});
        chk({tag, ".post_att"}, {25'd0, post_att}, {25'd0, w4[6:0]});
        chk({tag, ".cpmg"},    {24'd0, cpmg},        m_act[5] & 32'hFF);
        chk({tag, ".pblock"},  {24'd0, pulse_block}, m_act[6] & 32'hFF);
        chk({tag, ".pboff"},   {16'd0, pulse_block_off}, m_act[7] & 32'hFFFF);
        chk({tag, ".pump"},    {31'd0, pump},  {31'd0, w8[0]});
        chk({tag, ".block"},   {31'd0, block}, {31'd0, w8[1]});
        chk({tag, ".pending"}, {31'd0, commit_pending}, {31'd0, m_pending});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        cycle_start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Sends one frame with an explicit checksum byte and updates the model.
    task automatic send_frame_raw(input logic [7:0] addr, input logic [31:0] data, input logic [7:0] csum);
        logic ok;
        ok = (csum == (addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0])) && (addr <= 8'd9);
        send_byte(8'hA5);
        send_byte(addr);
        send_byte(data[31:24]);
        send_byte(data[23:16]);
        send_byte(data[15:8]);
        send_byte(data[7:0]);
        send_byte(csum);
        chk("frame_err_strobe", {31'd0, frame_err}, {31'd0, !ok});
        tick();
        chk("frame_err_clear", {31'd0, frame_err}, 32'd0);
        if (ok && addr == 8'd9) m_pending = 1'b1;
        else if (ok) m_shadow[addr] = data;
        else m_pending = m_pending;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [31:0] data);
        send_frame_raw(addr, data, addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0]);
    endtask

    task automatic pulse_cycle(input string tag);
        logic exp_applied;
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        exp_applied = m_pending;
        if (m_pending) for (int i = 0; i < 9; i++) m_act[i] = m_shadow[i];
        m_pending = 1'b0;
        chk({tag, ".applied"}, {31'd0, applied}, {31'd0, exp_applied});
        check_all(tag);
        tick();
        chk({tag, ".applied_once"}, {31'd0, applied}, 32'd0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [7:0]  rc;

        do_reset();
        check_all("reset");
        chk("reset.applied", {31'd0, applied}, 32'd0);
        chk("reset.frame_err", {31'd0, frame_err}, 32'd0);

        // delay=300 then COMMIT; outputs hold until the boundary
        send_frame(8'h02, 32'h0000012C);
        chk("delay_before_commit", delay, 32'd200);
        send_frame(8'h09, 32'h00000000);
        repeat (5) tick();
        check_all("commit_wait");
        pulse_cycle("apply_delay");
        chk("delay_applied", delay, 32'd300);

        // bad checksum on cpmg
        send_frame_raw(8'h05, 32'h00000003, 8'hFF);
        send_frame(8'h09, 32'h0);
        pulse_cycle("bad_csum");
        chk("cpmg_kept", {24'd0, cpmg}, 32'd1);

        // COMMIT coinciding with cycle_start: v=0 on the CSUM byte, v=1 on the strobe cycle
        for (int v = 0; v < 2; v++) begin
            send_frame(8'h01, 32'd77 + v);
            send_byte(8'hA5);
            send_byte(8'h09);
            repeat (4) send_byte(8'h00);
            bus.rx_data = 8'h09;
            bus.rx_valid = 1'b1;
            cycle_start = (v == 0);
            tick();
            bus.rx_valid = 1'b0;
            cycle_start = (v == 1);
            if (v == 0) chk("same_cycle_csum.applied", {31'd0, applied}, 32'd0);
            tick();
            cycle_start = 1'b0;
            chk("same_cycle.applied", {31'd0, applied}, 32'd0);
            m_pending = 1'b1;
            check_all("same_cycle_hold");
            pulse_cycle("same_cycle_next");
        end

        // writes after COMMIT are included in the apply
        send_frame(8'h03, 32'd80);
        send_frame(8'h09, 32'h0);
        send_frame(8'h03, 32'd100);
        pulse_cycle("late_write");
        chk("p2width_latest", p2width, 32'd100);

        // no range checks, multi-field words
        send_frame(8'h00, 32'd0);
        send_frame(8'h05, 32'hFFFFFF00);
        send_frame(8'h04, 32'h00007F55);
        send_frame(8'h08, 32'h00000002);
        send_frame(8'h07, 32'hABCD1234);
        send_frame(8'h09, 32'h0);
        pulse_cycle("zero_pass");

        // address beyond map is rejected
        send_frame(8'h0A, 32'h00000005);
        send_frame(8'h09, 32'h0);
        pulse_cycle("bad_addr");

        // uncommitted writes never reach outputs
        send_frame(8'h06, 32'd9);
        pulse_cycle("no_commit");

        // reset mid-frame discards the partial frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h2C);
        send_byte(8'h2F);
        tick();
        send_frame(8'h09, 32'h0);
        pulse_cycle("reset_midframe");

        // stalled partial frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
`ifdef FRAME_TIMEOUT_EN
        repeat (15) tick();
        chk("timeout_early", {31'd0, frame_err}, 32'd0);
        tick();
        chk("timeout_err", {31'd0, frame_err}, 32'd1);
        tick();
        chk("timeout_err_once", {31'd0, frame_err}, 32'd0);
        send_frame(8'h01, 32'd42);
`else
        repeat (16) tick();
        chk("no_timeout", {31'd0, frame_err}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h2A);
        send_byte(8'h2B);
        chk("stalled_frame_ok", {31'd0, frame_err}, 32'd0);
        tick();
        m_shadow[1] = 32'd42;
`endif
        send_frame(8'h09, 32'h0);
        pulse_cycle("stall");
        chk("stall_p1width", p1width, 32'd42);

        // randomized frames, commits and boundaries
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 11));
            rd = $urandom;
            if ($urandom_range(0, 3) == 0) rd[31:24] = 8'hA5;
            rc = ra ^ rd[31:24] ^ rd[23:16] ^ rd[15:8] ^ rd[7:0];
            if ($urandom_range(0, 4) == 0) rc = rc ^ (8'h01 << $urandom_range(0, 7));
            send_frame_raw(ra, rd, rc);
            if ($urandom_range(0, 2) == 0) send_frame(8'h09, $urandom);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 1) == 0) pulse_cycle("rand");
            else check_all("rand_hold");
        end
        send_frame(8'h09, 32'h0);
        pulse_cycle("rand_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
